// File: rtl/gesture_pkg.sv
// Shared types for the gesture frame sequencer: state encoding, default geometry,
// finger bit positions and the finger popcount helper.
package gesture_pkg;

    localparam int IMG_W_DEF = 120;
    localparam int IMG_H_DEF = 160;

    localparam int THUMB  = 4;
    localparam int INDEX  = 3;
    localparam int MIDDLE = 2;
    localparam int RING   = 1;
    localparam int PINKY  = 0;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        PALM,
        PALM_CHK,
        CLR2,
        FINGER,
        FIN_CHK,
        RESULT
    } state_t;

    function automatic logic [2:0] popcount5(input logic [4:0] m);
        popcount5 = 3'(m[THUMB]) + 3'(m[INDEX]) + 3'(m[MIDDLE])
                  + 3'(m[RING]) + 3'(m[PINKY]);
    endfunction

endpackage

// File: rtl/pixel_raster_counter.sv
// Raster row/column counter for one image frame; frame_end flags the last accepted pixel.
// Latency: counters update the cycle after adv; frame_end is combinational.
// Backpressure: none, the pixel stream cannot be stalled; clr overrides adv.
module pixel_raster_counter
    import gesture_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          frame_end
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

    logic col_last;
    logic row_last;

    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);
    assign frame_end = adv && row_last && col_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gesture_frame_sequencer.sv
// Two-pass gesture sequencer (palm frame(s), then finger frame(s)); GESTURE_CONFIRM_EN adds finger re-confirmation.
// Latency: res_valid 2*IMG_W*IMG_H+4 cycles after start on a first-try palm hit with continuous pixels.
// Backpressure: the result is held in RESULT until res_valid && res_ready; pixels outside PALM/FINGER are dropped.
module gesture_frame_sequencer
    import gesture_pkg::*;
#(
    parameter int IMG_W          = IMG_W_DEF,
    parameter int IMG_H          = IMG_H_DEF,
    parameter int MAX_PALM_TRIES = 3,
    parameter int CW             = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    input  logic          pix_in,
    input  logic          palm_found,
    input  logic [4:0]    finger_status,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          pix_out,
    output logic          stage_clr,
    output logic          palm_en,
    output logic          finger_en,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [4:0]    res_mask,
    output logic [2:0]    res_count,
    output logic          res_nohand
);

    localparam logic [7:0] TRY_LAST = 8'(MAX_PALM_TRIES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tries;
    logic       frame_end;
    logic       cnt_clr;
    logic       cnt_adv;
    logic       fin_done;

    assign cnt_adv = pix_valid && ((state == PALM) || (state == FINGER));
    assign cnt_clr = (state == CLR) || (state == CLR2);
    assign pix_out = pix_in && pix_valid;

    pixel_raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .adv       (cnt_adv),
        .row       (row),
        .col       (col),
        .frame_end (frame_end)
    );

`ifdef GESTURE_CONFIRM_EN
    logic [4:0] cand;
    logic [1:0] fin_frames;

    // The candidate starts at zero, so an all-zero first mask already counts as agreement.
    assign fin_done = (finger_status == cand) || (fin_frames == 2'd2);
`else
    assign fin_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = CLR;
            CLR:      state_nxt = PALM;
            PALM:     if (frame_end) state_nxt = PALM_CHK;
            PALM_CHK: begin
                if (palm_found) begin
                    state_nxt = CLR2;
                end else if (tries < TRY_LAST) begin
                    state_nxt = CLR;
                end else begin
                    state_nxt = RESULT;
                end
            end
            CLR2:     state_nxt = FINGER;
            FINGER:   if (frame_end) state_nxt = FIN_CHK;
            FIN_CHK:  state_nxt = fin_done ? RESULT : CLR2;
            RESULT:   if (res_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stage_clr = 1'b0;
        palm_en   = 1'b0;
        finger_en = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state)
            IDLE:    busy      = 1'b0;
            CLR:     stage_clr = 1'b1;
            CLR2:    stage_clr = 1'b1;
            PALM:    palm_en   = pix_valid;
            FINGER:  finger_en = pix_valid;
            RESULT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tries      <= '0;
            res_mask   <= '0;
            res_count  <= '0;
            res_nohand <= 1'b0;
`ifdef GESTURE_CONFIRM_EN
            cand       <= '0;
            fin_frames <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tries <= '0;
`ifdef GESTURE_CONFIRM_EN
                        cand       <= '0;
                        fin_frames <= '0;
`endif
                    end
                end
                PALM_CHK: begin
                    if (!palm_found) begin
                        if (tries < TRY_LAST) begin
                            tries <= tries + 1'b1;
                        end else begin
                            res_nohand <= 1'b1;
                            res_mask   <= '0;
                            res_count  <= '0;
                        end
                    end
                end
                FIN_CHK: begin
                    if (fin_done) begin
                        res_mask   <= finger_status;
                        res_count  <= popcount5(finger_status);
                        res_nohand <= 1'b0;
                    end
`ifdef GESTURE_CONFIRM_EN
                    else begin
                        cand       <= finger_status;
                        fin_frames <= fin_frames + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_frame_sequencer.sv
// Directed bench for gesture_frame_sequencer on a reduced 20x16 raster with a pixel-index reference model.
module tb_gesture_frame_sequencer;

    localparam int TW    = 20;
    localparam int TH    = 16;
    localparam int CWB   = 5;
    localparam int MAXT  = 3;
    localparam int NPIX  = TW * TH;
    localparam int BOUND = 3000;

    logic            clk;
    logic            rst;
    logic            start;
    logic            pix_valid;
    logic            pix_in;
    logic            palm_found;
    logic [4:0]      finger_status;
    logic [CWB-1:0]  row;
    logic [CWB-1:0]  col;
    logic            pix_out;
    logic            stage_clr;
    logic            palm_en;
    logic            finger_en;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic [4:0]      res_mask;
    logic [2:0]      res_count;
    logic            res_nohand;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    gesture_frame_sequencer #(
        .IMG_W          (TW),
        .IMG_H          (TH),
        .MAX_PALM_TRIES (MAXT),
        .CW             (CWB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pix_valid     (pix_valid),
        .pix_in        (pix_in),
        .palm_found    (palm_found),
        .finger_status (finger_status),
        .row           (row),
        .col           (col),
        .pix_out       (pix_out),
        .stage_clr     (stage_clr),
        .palm_en       (palm_en),
        .finger_en     (finger_en),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_mask      (res_mask),
        .res_count     (res_count),
        .res_nohand    (res_nohand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase of the attempt plus a linear pixel index within the frame.
    // Phases: 0 idle, 1 palm clear, 2 palm frame, 3 palm decision,
    //         4 finger clear, 5 finger frame, 6 finger decision, 7 result held.
    int         m_ph    = 0;
    int         m_pidx  = 0;
    int         m_tries = 0;
    int         m_ffr   = 0;
    logic [4:0] m_cand  = '0;
    logic [4:0] m_mask  = '0;
    logic [2:0] m_count = '0;
    logic       m_nohand = 1'b0;

    task automatic model_report(input logic [4:0] fs);
        m_mask   = fs;
        m_count  = 3'($countones(fs));
        m_nohand = 1'b0;
        m_ph     = 7;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_pidx = 0; m_tries = 0; m_ffr = 0; m_cand = '0;
            m_mask = '0; m_count = '0; m_nohand = 1'b0;
        end else begin
            case (m_ph)
                0: if (start) begin m_ph = 1; m_tries = 0; m_ffr = 0; m_cand = '0; end
                1: begin m_pidx = 0; m_ph = 2; end
                2, 5: if (pix_valid) begin
                    if (m_pidx == NPIX - 1) begin m_pidx = 0; m_ph = m_ph + 1; end
                    else m_pidx++;
                end
                3: begin
                    if (palm_found) m_ph = 4;
                    else if (m_tries < MAXT - 1) begin m_tries++; m_ph = 1; end
                    else begin m_nohand = 1'b1; m_mask = '0; m_count = '0; m_ph = 7; end
                end
                4: begin m_pidx = 0; m_ph = 5; end
                6: begin
                    m_ffr++;
`ifdef GESTURE_CONFIRM_EN
                    if (finger_status == m_cand || m_ffr == 3) model_report(finger_status);
                    else begin m_cand = finger_status; m_ph = 4; end
`else
                    model_report(finger_status);
`endif
                end
                7: if (res_ready) m_ph = 0;
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en && n_fail < 50) begin
            logic [31:0] act_v;
            logic [31:0] exp_v;
            logic [CWB-1:0] e_row;
            logic [CWB-1:0] e_col;
            e_row = CWB'(m_pidx / TW);
            e_col = CWB'(m_pidx % TW);
            act_v = {7'd0, row, col, pix_out, stage_clr, palm_en, finger_en, busy,
                     res_valid, res_mask, res_count, res_nohand};
            exp_v = {7'd0, e_row, e_col, pix_in & pix_valid, (m_ph == 1 || m_ph == 4),
                     (m_ph == 2) & pix_valid, (m_ph == 5) & pix_valid, (m_ph != 0),
                     (m_ph == 7), m_mask, m_count, m_nohand};
            check("cycle_outputs", act_v, exp_v);
        end
    end

    // Caller raises start just after an edge; this returns once res_valid is seen.
    task automatic run_attempt(input bit toggle, input bit sw, output int lat, output int clrs,
                               output int pe, output int lr, output int lc);
        lat = 0; clrs = 0; pe = 0; lr = -1; lc = -1;
        @(posedge clk); #1;
        start = 1'b0;
        if (stage_clr) clrs++;
        if (toggle) pix_valid = ~pix_valid;
        while (!res_valid && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
            if (stage_clr) begin
                clrs++;
                if (sw && clrs == 3) finger_status = 5'b00111;
            end
            if (palm_en) begin pe++; lr = int'(row); lc = int'(col); end
            if (toggle) pix_valid = ~pix_valid;
        end
        check("result_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic ack_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("idle_after_ack_busy", {31'd0, busy}, 32'd0);
        check("idle_after_ack_valid", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        int lat, clrs, pe, lr, lc;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 1'b0;
        palm_found = 1'b0; finger_status = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_row_col", {22'd0, row, col}, 32'd0);
        check("reset_result", {23'd0, res_valid, res_mask, res_count}, 32'd0);

        // Palm on first try, continuous pixels, with object pixels flowing through.
        pix_valid = 1'b1; pix_in = 1'b1; palm_found = 1'b1; finger_status = 5'b01100;
        start = 1'b1;
        run_attempt(1'b0, 1'b0, lat, clrs, pe, lr, lc);
        check("palm_hit_latency", lat, 32'd644);
        check("palm_hit_mask", {27'd0, res_mask}, 32'b01100);
        check("palm_hit_count", {29'd0, res_count}, 32'd2);
        check("palm_hit_nohand", {31'd0, res_nohand}, 32'd0);
        check("palm_hit_clr_pulses", clrs, 32'd2);
        pix_in = 1'b0;

        // Host stalls for 10 cycles; a start during RESULT must be ignored.
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(posedge clk); #1;
            check("stall_valid", {31'd0, res_valid}, 32'd1);
            check("stall_busy", {31'd0, busy}, 32'd1);
            check("stall_mask", {24'd0, res_mask, res_count}, {24'd0, 5'b01100, 3'd2});
        end
        start = 1'b0;
        ack_result();

        // No palm in any of the three tries.
        palm_found = 1'b0;
        start = 1'b1;
        run_attempt(1'b0, 1'b0, lat, clrs, pe, lr, lc);
        check("nohand_latency", lat, 32'd966);
        check("nohand_flag", {31'd0, res_nohand}, 32'd1);
        check("nohand_mask_count", {24'd0, res_mask, res_count}, 32'd0);
        check("nohand_clr_pulses", clrs, 32'd3);
        check("nohand_palm_en_cycles", pe, 32'd960);
        ack_result();

        // Pixel valid toggling every cycle.
        palm_found = 1'b1; finger_status = 5'b10101; pix_valid = 1'b0;
        start = 1'b1;
        run_attempt(1'b1, 1'b0, lat, clrs, pe, lr, lc);
        check("toggle_palm_en_cycles", pe, NPIX);
        check("toggle_frame_end_row", lr, TH - 1);
        check("toggle_frame_end_col", lc, TW - 1);
        check("toggle_mask_count", {24'd0, res_mask, res_count}, {24'd0, 5'b10101, 3'd3});
        ack_result();

        // Reset while in the finger frame at the middle row.
        pix_valid = 1'b1; pix_in = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!(finger_en && int'(row) == TH / 2) && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mid_finger_reached", {31'd0, finger_en}, 32'd1);
        rst = 1'b1; pix_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_en", {29'd0, busy, palm_en, finger_en}, 32'd0);
        check("rst_row_col", {22'd0, row, col}, 32'd0);
        check("rst_outputs", {21'd0, pix_out, stage_clr, res_valid, res_mask, res_count, res_nohand}, 32'd0);
        rst = 1'b0; pix_in = 1'b0;
        @(posedge clk); #1;

        // Finger mask changes between frames: 00011 then 00111 from the second frame on.
        pix_valid = 1'b1; palm_found = 1'b1; finger_status = 5'b00011;
        start = 1'b1;
        run_attempt(1'b0, 1'b1, lat, clrs, pe, lr, lc);
`ifdef GESTURE_CONFIRM_EN
        check("confirm_latency", lat, 32'd1288);
        check("confirm_clr_pulses", clrs, 32'd4);
        check("confirm_mask_count", {24'd0, res_mask, res_count}, {24'd0, 5'b00111, 3'd3});
`else
        check("single_latency", lat, 32'd644);
        check("single_clr_pulses", clrs, 32'd2);
        check("single_mask_count", {24'd0, res_mask, res_count}, {24'd0, 5'b00011, 3'd2});
`endif
        ack_result();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
